// File: rtl/tcp_phy_tx_arbiter_if.sv
// rtl/tcp_phy_tx_arbiter_if.sv - byte stream bundle shared by the arbiter's source and PHY ports
interface tcp_phy_tx_arbiter_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tcp_phy_tx_arbiter.sv
// rtl/tcp_phy_tx_arbiter.sv - frame-atomic ctrl/data arbiter onto the PHY tx stream
// Ctrl wins ties unless data has lost STARVE_LIMIT consecutive grants; frames are capped and gapped.
module tcp_phy_tx_arbiter #(
  parameter int STARVE_LIMIT  = 4,
  parameter int IFG_CYCLES    = 12,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  tcp_phy_tx_arbiter_if.slave         s_ctrl_axis,
  tcp_phy_tx_arbiter_if.slave         s_data_axis,
  tcp_phy_tx_arbiter_if.master        phy_axis,
  output logic                        grant_ctrl,
  output logic                        grant_data,
  output logic                        busy,
  output logic                        err_oversize,
  output logic [15:0]                 frame_cnt
);

  localparam int BW = $clog2(MAX_FRAME_LEN + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int GW = $clog2(IFG_CYCLES + 2);
  localparam logic [BW-1:0] TRUNC_AT   = BW'(MAX_FRAME_LEN - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [GW-1:0] GAP_LAST   = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, FWD_CTRL, FWD_DATA, DRAIN, GAP} state_t;
  localparam state_t END_STATE = (IFG_CYCLES == 0) ? IDLE : GAP;

  state_t        state;
  logic          sel_data;
  logic [BW-1:0] byte_cnt;
  logic [SW-1:0] starve_cnt;
  logic [GW-1:0] gap_cnt;

  logic       fwd;
  logic [7:0] src_tdata;
  logic       src_valid;
  logic       src_last;
  logic       src_ready;
  logic       trunc;
  logic       phy_hs;
  logic       drain_hs;

  // sel_data stays valid through DRAIN so the discarded tail comes from the owning source
  always_comb begin
    fwd            = (state == FWD_CTRL) || (state == FWD_DATA);
    src_tdata      = sel_data ? s_data_axis.tdata  : s_ctrl_axis.tdata;
    src_valid      = sel_data ? s_data_axis.tvalid : s_ctrl_axis.tvalid;
    src_last       = sel_data ? s_data_axis.tlast  : s_ctrl_axis.tlast;
    trunc          = (byte_cnt == TRUNC_AT);
    src_ready      = fwd ? phy_axis.tready : (state == DRAIN);
    phy_axis.tdata  = fwd ? src_tdata : 8'h00;
    phy_axis.tvalid = fwd & src_valid;
    phy_axis.tlast  = fwd & (src_last | trunc);
    s_ctrl_axis.tready = src_ready & ~sel_data;
    s_data_axis.tready = src_ready & sel_data;
    phy_hs         = fwd & src_valid & phy_axis.tready;
    drain_hs       = (state == DRAIN) & src_valid;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sel_data     <= 1'b0;
      byte_cnt     <= '0;
      starve_cnt   <= '0;
      gap_cnt      <= '0;
      grant_ctrl   <= 1'b0;
      grant_data   <= 1'b0;
      err_oversize <= 1'b0;
      frame_cnt    <= 16'h0000;
    end else begin
      err_oversize <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (s_ctrl_axis.tvalid || s_data_axis.tvalid)) begin
            byte_cnt <= '0;
            if (s_data_axis.tvalid && (!s_ctrl_axis.tvalid || starve_cnt == STARVE_MAX)) begin
              state      <= FWD_DATA;
              sel_data   <= 1'b1;
              grant_data <= 1'b1;
              starve_cnt <= '0;
            end else begin
              state      <= FWD_CTRL;
              sel_data   <= 1'b0;
              grant_ctrl <= 1'b1;
              if (s_data_axis.tvalid && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        FWD_CTRL, FWD_DATA: begin
          if (phy_hs) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (src_last) begin
              frame_cnt  <= frame_cnt + 16'd1;
              grant_ctrl <= 1'b0;
              grant_data <= 1'b0;
              gap_cnt    <= '0;
              state      <= END_STATE;
            end else if (trunc) begin
              frame_cnt    <= frame_cnt + 16'd1;
              err_oversize <= 1'b1;
              state        <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_hs && src_last) begin
            grant_ctrl <= 1'b0;
            grant_data <= 1'b0;
            gap_cnt    <= '0;
            state      <= END_STATE;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_phy_tx_arbiter.sv
// tb/tb_tcp_phy_tx_arbiter.sv - randomized bench for tcp_phy_tx_arbiter with a frame-level model
module tb_tcp_phy_tx_arbiter;
  localparam int IFG = 12;
  localparam int STARVE = 4;
  localparam int SMALL_MAX = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  tcp_phy_tx_arbiter_if ctrl_if ();
  tcp_phy_tx_arbiter_if data_if ();
  tcp_phy_tx_arbiter_if phy_if ();
  tcp_phy_tx_arbiter_if sctrl_if ();
  tcp_phy_tx_arbiter_if sdata_if ();
  tcp_phy_tx_arbiter_if sphy_if ();

  logic grant_ctrl, grant_data, busy, err_oversize;
  logic [15:0] frame_cnt;
  logic s_grant_ctrl, s_grant_data, s_busy, s_err;
  logic [15:0] s_frame_cnt;

  tcp_phy_tx_arbiter #(.STARVE_LIMIT(STARVE), .IFG_CYCLES(IFG), .MAX_FRAME_LEN(1518)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_ctrl_axis(ctrl_if), .s_data_axis(data_if), .phy_axis(phy_if),
    .grant_ctrl(grant_ctrl), .grant_data(grant_data), .busy(busy),
    .err_oversize(err_oversize), .frame_cnt(frame_cnt)
  );

  tcp_phy_tx_arbiter #(.STARVE_LIMIT(STARVE), .IFG_CYCLES(IFG), .MAX_FRAME_LEN(SMALL_MAX)) dut_small (
    .clk(clk), .rst(rst), .enable(enable),
    .s_ctrl_axis(sctrl_if), .s_data_axis(sdata_if), .phy_axis(sphy_if),
    .grant_ctrl(s_grant_ctrl), .grant_data(s_grant_data), .busy(s_busy),
    .err_oversize(s_err), .frame_cnt(s_frame_cnt)
  );

  logic [8:0] ctrl_q[$], data_q[$], sctrl_q[$];
  logic [7:0] c_bytes[$], d_bytes[$], s_exp[$];
  int c_len[$], d_len[$];
  logic [7:0] cur[$], got_data[$], s_got[$];
  int got_len[$], glog[$], gcyc[$], tl_cyc[$], s_tl_pos[$];
  bit got_src[$];
  int cyc = 0;
  int err_cnt_main = 0, s_err_cnt = 0, s_src_hs = 0;
  bit c_gaps = 0, d_gaps = 0;
  int rdy_mode = 0;
  int checks = 0, failures = 0, fc_exp = 0;

  task automatic push_frame(input bit is_data, input int len);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      if (is_data) begin data_q.push_back({(k == len - 1), b}); d_bytes.push_back(b); end
      else begin ctrl_q.push_back({(k == len - 1), b}); c_bytes.push_back(b); end
    end
    if (is_data) d_len.push_back(len); else c_len.push_back(len);
  endtask

  initial begin : ctrl_drv
    bit hs;
    ctrl_if.tvalid = 0; ctrl_if.tdata = 0; ctrl_if.tlast = 0;
    forever begin
      @(negedge clk); hs = ctrl_if.tvalid && ctrl_if.tready;
      @(posedge clk); #1;
      if (hs && !rst && ctrl_q.size() > 0) void'(ctrl_q.pop_front());
      if (ctrl_q.size() > 0 && !(c_gaps && $urandom_range(0, 3) == 0)) begin
        ctrl_if.tvalid = 1; ctrl_if.tlast = ctrl_q[0][8]; ctrl_if.tdata = ctrl_q[0][7:0];
      end else begin
        ctrl_if.tvalid = 0; ctrl_if.tlast = 0;
      end
    end
  end

  initial begin : data_drv
    bit hs;
    data_if.tvalid = 0; data_if.tdata = 0; data_if.tlast = 0;
    forever begin
      @(negedge clk); hs = data_if.tvalid && data_if.tready;
      @(posedge clk); #1;
      if (hs && !rst && data_q.size() > 0) void'(data_q.pop_front());
      if (data_q.size() > 0 && !(d_gaps && $urandom_range(0, 3) == 0)) begin
        data_if.tvalid = 1; data_if.tlast = data_q[0][8]; data_if.tdata = data_q[0][7:0];
      end else begin
        data_if.tvalid = 0; data_if.tlast = 0;
      end
    end
  end

  initial begin : sctrl_drv
    bit hs;
    sctrl_if.tvalid = 0; sctrl_if.tdata = 0; sctrl_if.tlast = 0;
    forever begin
      @(negedge clk); hs = sctrl_if.tvalid && sctrl_if.tready;
      @(posedge clk); #1;
      if (hs && !rst && sctrl_q.size() > 0) void'(sctrl_q.pop_front());
      if (sctrl_q.size() > 0) begin
        sctrl_if.tvalid = 1; sctrl_if.tlast = sctrl_q[0][8]; sctrl_if.tdata = sctrl_q[0][7:0];
      end else begin
        sctrl_if.tvalid = 0; sctrl_if.tlast = 0;
      end
    end
  end

  initial begin : rdy_drv
    phy_if.tready = 1; sphy_if.tready = 1;
    sdata_if.tvalid = 0; sdata_if.tdata = 0; sdata_if.tlast = 0;
    forever begin
      @(posedge clk); cyc++; #1;
      case (rdy_mode)
        1: phy_if.tready = ~phy_if.tready;
        2: phy_if.tready = ($urandom_range(0, 2) != 0);
        default: phy_if.tready = 1;
      endcase
    end
  end

  initial begin : mon
    bit gc_prev, gd_prev;
    gc_prev = 0; gd_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) cur.delete();
      else begin
        if (grant_ctrl && !gc_prev) begin glog.push_back(0); gcyc.push_back(cyc); end
        if (grant_data && !gd_prev) begin glog.push_back(1); gcyc.push_back(cyc); end
        if (err_oversize) err_cnt_main++;
        if (phy_if.tvalid && phy_if.tready) begin
          cur.push_back(phy_if.tdata);
          if (phy_if.tlast) begin
            got_len.push_back(cur.size()); got_src.push_back(grant_data);
            foreach (cur[k]) got_data.push_back(cur[k]);
            tl_cyc.push_back(cyc); cur.delete();
          end
        end
        if (s_err) s_err_cnt++;
        if (sctrl_if.tvalid && sctrl_if.tready) s_src_hs++;
        if (sphy_if.tvalid && sphy_if.tready) begin
          s_got.push_back(sphy_if.tdata);
          if (sphy_if.tlast) s_tl_pos.push_back(s_got.size());
        end
      end
      gc_prev = grant_ctrl; gd_prev = grant_data;
    end
  end

  // Reference: every PHY frame is the next unsent frame of whichever source owned the grant
  function automatic int score_frames();
    int bad = 0, pos = 0;
    for (int i = 0; i < got_len.size(); i++) begin
      int L = 0; bit m = 0; logic [7:0] e;
      if (got_src[i] ? (d_len.size() == 0) : (c_len.size() == 0)) bad++;
      else begin
        L = got_src[i] ? d_len.pop_front() : c_len.pop_front();
        if (L != got_len[i]) m = 1;
        for (int k = 0; k < L; k++) begin
          e = got_src[i] ? d_bytes.pop_front() : c_bytes.pop_front();
          if (k < got_len[i] && got_data[pos + k] !== e) m = 1;
        end
        if (m) bad++;
      end
      pos += got_len[i];
    end
    bad += c_len.size() + d_len.size();
    got_len.delete(); got_src.delete(); got_data.delete();
    c_len.delete(); d_len.delete(); c_bytes.delete(); d_bytes.delete();
    return bad;
  endfunction

  task automatic wait_idle(input int lim, output bit ok);
    int run = 0;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (ctrl_q.size() == 0 && data_q.size() == 0 && !busy && cur.size() == 0) run++; else run = 0;
      if (run >= 3) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1; enable = 0;
    repeat (2) @(negedge clk);
    v = {phy_if.tvalid, phy_if.tlast, ctrl_if.tready, data_if.tready, grant_ctrl, grant_data, busy, err_oversize};
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_flags got=%b exp=00000000", v); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    checks++; if (phy_if.tdata !== 8'h00) begin failures++; $display("FAIL reset_tdata got=%0h exp=0", phy_if.tdata); end
    @(posedge clk); #1 rst = 0; enable = 1;
  endtask

  task automatic test_single_ctrl();
    bit ok; int d, bad;
    push_frame(0, 3); fc_exp += 1;
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ctrl3_timeout got=busy exp=idle"); end
    checks++; if (frame_cnt !== 16'(fc_exp)) begin failures++; $display("FAIL ctrl3_frame_cnt got=%0d exp=%0d", frame_cnt, fc_exp); end
    bad = score_frames();
    checks++; if (bad !== 0) begin failures++; $display("FAIL ctrl3_frames got=%0d bad exp=0", bad); end
    glog.delete(); gcyc.delete(); tl_cyc.delete();
    push_frame(0, 2); push_frame(0, 1); fc_exp += 2;
    wait_idle(200, ok);
    bad = score_frames();
    checks++; if (bad !== 0) begin failures++; $display("FAIL ifg_frames got=%0d bad exp=0", bad); end
    d = (gcyc.size() == 2 && tl_cyc.size() == 2) ? gcyc[1] - tl_cyc[0] : -1;
    checks++; if (d !== IFG + 2) begin failures++; $display("FAIL ifg_spacing got=%0d exp=%0d", d, IFG + 2); end
  endtask

  task automatic test_starvation();
    bit ok; int pc = 10, pd = 2, st = 0, n = 0, bad;
    logic [31:0] gp, ep;
    gp = '0; ep = '0;
    glog.delete(); gcyc.delete();
    for (int i = 0; i < 10; i++) push_frame(0, $urandom_range(1, 6));
    for (int i = 0; i < 2; i++) push_frame(1, $urandom_range(1, 6));
    fc_exp += 12;
    wait_idle(3000, ok);
    while (pc > 0 || pd > 0) begin
      if (pd > 0 && (pc == 0 || st == STARVE)) begin ep[n] = 1; pd--; st = 0; end
      else begin ep[n] = 0; pc--; if (pd > 0 && st < STARVE) st++; end
      n++;
    end
    foreach (glog[i]) if (i < 32) gp[i] = (glog[i] != 0);
    checks++; if (glog.size() !== n) begin failures++; $display("FAIL starve_grants got=%0d exp=%0d", glog.size(), n); end
    checks++; if (gp !== ep) begin failures++; $display("FAIL starve_order got=%b exp=%b", gp, ep); end
    bad = score_frames();
    checks++; if (bad !== 0) begin failures++; $display("FAIL starve_frames got=%0d bad exp=0", bad); end
    checks++; if (frame_cnt !== 16'(fc_exp)) begin failures++; $display("FAIL starve_frame_cnt got=%0d exp=%0d", frame_cnt, fc_exp); end
  endtask

  task automatic test_data_stall();
    bit ok; int bad, nf;
    rdy_mode = 1; d_gaps = 1;
    push_frame(1, 64); fc_exp += 1;
    wait_idle(1000, ok);
    nf = got_len.size();
    checks++; if (nf !== 1) begin failures++; $display("FAIL stall_frame_count got=%0d exp=1", nf); end
    bad = score_frames();
    checks++; if (bad !== 0) begin failures++; $display("FAIL stall_frames got=%0d bad exp=0", bad); end
    rdy_mode = 0; d_gaps = 0;
  endtask

  task automatic test_truncation();
    logic [7:0] b; bit m = 0; int run = 0;
    for (int k = 0; k < 20; k++) begin b = 8'($urandom); sctrl_q.push_back({(k == 19), b}); s_exp.push_back(b); end
    for (int i = 0; i < 400 && run < 3; i++) begin @(negedge clk); if (sctrl_q.size() == 0 && !s_busy) run++; else run = 0; end
    checks++; if (s_got.size() !== 16) begin failures++; $display("FAIL trunc_len got=%0d exp=16", s_got.size()); end
    for (int k = 0; k < 16 && k < s_got.size(); k++) if (s_got[k] !== s_exp[k]) m = 1;
    checks++; if (m) begin failures++; $display("FAIL trunc_bytes got=differ exp=first16"); end
    checks++; if (s_tl_pos.size() !== 1 || s_tl_pos[0] !== 16) begin failures++; $display("FAIL trunc_tlast got=%0d tlasts exp=1 at 16", s_tl_pos.size()); end
    checks++; if (s_err_cnt !== 1) begin failures++; $display("FAIL trunc_err got=%0d exp=1", s_err_cnt); end
    checks++; if (s_src_hs !== 20) begin failures++; $display("FAIL trunc_drain got=%0d exp=20", s_src_hs); end
    checks++; if (s_frame_cnt !== 16'd1) begin failures++; $display("FAIL trunc_frame_cnt got=%0d exp=1", s_frame_cnt); end
    for (int k = 0; k < 16; k++) begin b = 8'($urandom); sctrl_q.push_back({(k == 15), b}); end
    run = 0;
    for (int i = 0; i < 400 && run < 3; i++) begin @(negedge clk); if (sctrl_q.size() == 0 && !s_busy) run++; else run = 0; end
    checks++; if (s_tl_pos.size() !== 2 || s_got.size() !== 32) begin failures++; $display("FAIL exact_max_len got=%0d exp=32", s_got.size()); end
    checks++; if (s_err_cnt !== 1) begin failures++; $display("FAIL exact_max_err got=%0d exp=1", s_err_cnt); end
    checks++; if (s_frame_cnt !== 16'd2) begin failures++; $display("FAIL exact_max_frame_cnt got=%0d exp=2", s_frame_cnt); end
  endtask

  task automatic test_enable_drop();
    bit ok, hit = 0; int bad;
    glog.delete(); gcyc.delete();
    push_frame(0, 10);
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (cur.size() >= 4) begin hit = 1; break; end end
    enable = 0;
    checks++; if (!hit) begin failures++; $display("FAIL en_drop_start got=no_beats exp=4"); end
    push_frame(0, 3); push_frame(1, 3); fc_exp += 3;
    repeat (60) @(negedge clk);
    checks++; if (got_len.size() !== 1 || got_len[0] !== 10) begin failures++; $display("FAIL en_drop_frame got=%0d frames exp=1x10", got_len.size()); end
    checks++; if (glog.size() !== 1 || busy !== 1'b0) begin failures++; $display("FAIL en_drop_hold got=%0d grants busy=%0b exp=1 busy=0", glog.size(), busy); end
    enable = 1;
    wait_idle(500, ok);
    bad = score_frames();
    checks++; if (!ok || bad !== 0) begin failures++; $display("FAIL en_resume got=%0d bad exp=0", bad); end
    checks++; if (frame_cnt !== 16'(fc_exp)) begin failures++; $display("FAIL en_frame_cnt got=%0d exp=%0d", frame_cnt, fc_exp); end
  endtask

  task automatic test_random_mix();
    bit ok; int bad;
    for (int r = 0; r < 2; r++) begin
      c_gaps = 1; d_gaps = 1; rdy_mode = 2; err_cnt_main = 0;
      for (int i = 0; i < 8; i++) begin
        push_frame(0, $urandom_range(1, 40)); push_frame(1, $urandom_range(1, 40));
      end
      fc_exp += 16;
      wait_idle(20000, ok);
      bad = score_frames();
      checks++; if (!ok || bad !== 0) begin failures++; $display("FAIL rand_frames round=%0d got=%0d bad exp=0", r, bad); end
      checks++; if (frame_cnt !== 16'(fc_exp)) begin failures++; $display("FAIL rand_frame_cnt got=%0d exp=%0d", frame_cnt, fc_exp); end
      checks++; if (err_cnt_main !== 0) begin failures++; $display("FAIL rand_err got=%0d exp=0", err_cnt_main); end
    end
    c_gaps = 0; d_gaps = 0; rdy_mode = 0;
  endtask

  task automatic test_reset_mid();
    bit ok, hit = 0; int bad;
    logic [7:0] v;
    push_frame(0, 12);
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (cur.size() >= 7) begin hit = 1; break; end end
    rst = 1;
    #1;
    v = {phy_if.tvalid, phy_if.tlast, ctrl_if.tready, data_if.tready, grant_ctrl, grant_data, busy, err_oversize};
    checks++; if (!hit || v !== 8'h00) begin failures++; $display("FAIL rst_mid_flags got=%b exp=00000000", v); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL rst_mid_frame_cnt got=%0d exp=0", frame_cnt); end
    ctrl_q.delete(); c_bytes.delete(); c_len.delete();
    got_len.delete(); got_src.delete(); got_data.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 0;
    fc_exp = 0;
    push_frame(1, 5); fc_exp += 1;
    wait_idle(300, ok);
    bad = score_frames();
    checks++; if (!ok || bad !== 0) begin failures++; $display("FAIL rst_mid_next got=%0d bad exp=0", bad); end
    checks++; if (frame_cnt !== 16'(fc_exp)) begin failures++; $display("FAIL rst_mid_restart got=%0d exp=%0d", frame_cnt, fc_exp); end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_ctrl();
    test_starvation();
    test_data_stall();
    test_truncation();
    test_enable_drop();
    test_random_mix();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
